// File: rtl/dot_update_queue.sv
// dot_update_queue: buffers dot-position writes from the processor and
// replays them to the VGA controller only during vertical blanking, one
// isolated dotWren pulse per entry, so dot registers never change mid-frame.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a screen_end rising edge with entries queued
//   STROBE | dotWren high, head entry presented, popped at end of cycle
//   GAP    | dotWren low; decide whether another entry may be replayed
module dot_update_queue #(
    parameter int DEPTH         = 16,
    parameter int NUM_DOTS      = 20,
    parameter int MAX_PER_FRAME = 64,
    parameter int X_MAX         = 639,
    parameter int Y_MAX         = 479
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic                     wr_is_y,
    input  logic [31:0]              wr_id,
    input  logic [31:0]              wr_loc,
    output logic                     wr_ready,
    input  logic                     screen_end,
    input  logic                     active,
    output logic                     dotWren,
    output logic                     is_Yloc,
    output logic [31:0]              dotID,
    output logic [31:0]              dotLoc,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(MAX_PER_FRAME + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    // entry layout: {is_y, id[4:0], loc[9:0]}
    logic [15:0]   mem_q [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [BW-1:0] budget_q, budget_d;
    logic          wr_ready_q, wr_ready_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_q, drop_d;
    logic          se_q, se_d;
    logic          dotwren_q, dotwren_d;
    logic          is_y_q, is_y_d;
    logic [4:0]    dot_id_q, dot_id_d;
    logic [9:0]    dot_loc_q, dot_loc_d;

    logic          id_ok, full, push, pop, start;
    logic [9:0]    loc_clamped;
    logic [15:0]   wr_entry, head;

    // Write-side decode: ID range, clamping, acceptance and error tracking.
    always_comb begin
        id_ok      = (wr_id < 32'(NUM_DOTS));
        full       = (level_q == LW'(DEPTH));
        push       = wr_valid & id_ok & ~full;
        pop        = (state_q == STROBE);
        if (wr_is_y) begin
            loc_clamped = (wr_loc > 32'(Y_MAX)) ? 10'(Y_MAX) : {1'b0, wr_loc[8:0]};
        end else begin
            loc_clamped = (wr_loc > 32'(X_MAX)) ? 10'(X_MAX) : wr_loc[9:0];
        end
        wr_entry   = {wr_is_y, wr_id[4:0], loc_clamped};
        head       = mem_q[rd_ptr_q];
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        wr_ready_d = (level_d != LW'(DEPTH));
        overflow_d = overflow_q | (wr_valid & full);
        drop_d     = drop_q;
        if (wr_valid && !id_ok && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        se_d       = screen_end;
        start      = screen_end & ~se_q;
    end

    // Replay sequencer: one strobe, one gap, repeat while blanking and budget allow.
    always_comb begin
        state_d   = state_q;
        budget_d  = budget_q;
        dotwren_d = 1'b0;
        is_y_d    = is_y_q;
        dot_id_d  = dot_id_q;
        dot_loc_d = dot_loc_q;
        case (state_q)
            IDLE: begin
                if (start && level_q != '0) begin
                    budget_d  = BW'(MAX_PER_FRAME);
                    state_d   = STROBE;
                    dotwren_d = 1'b1;
                    is_y_d    = head[15];
                    dot_id_d  = head[14:10];
                    dot_loc_d = head[9:0];
                end
            end
            STROBE: begin
                budget_d = budget_q - BW'(1);
                state_d  = GAP;
            end
            GAP: begin
                if (level_q != '0 && budget_q != '0 && !active) begin
                    state_d   = STROBE;
                    dotwren_d = 1'b1;
                    is_y_d    = head[15];
                    dot_id_d  = head[14:10];
                    dot_loc_d = head[9:0];
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            budget_q   <= '0;
            wr_ready_q <= 1'b1;
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
            se_q       <= 1'b0;
            dotwren_q  <= 1'b0;
            is_y_q     <= 1'b0;
            dot_id_q   <= 5'd0;
            dot_loc_q  <= 10'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            budget_q   <= budget_d;
            wr_ready_q <= wr_ready_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            se_q       <= se_d;
            dotwren_q  <= dotwren_d;
            is_y_q     <= is_y_d;
            dot_id_q   <= dot_id_d;
            dot_loc_q  <= dot_loc_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign dotWren    = dotwren_q;
    assign is_Yloc    = is_y_q;
    assign dotID      = {27'd0, dot_id_q};
    assign dotLoc     = {22'd0, dot_loc_q};

endmodule

// File: tb/tb_dot_update_queue.sv
// Bench for dot_update_queue: a queue-based model of expected replays plus
// directed scenarios with hand-computed timing and values.
module tb_dot_update_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_is_y = 1'b0;
    logic [31:0] wr_id = '0;
    logic [31:0] wr_loc = '0;
    logic        screen_end = 1'b0;
    logic        active = 1'b0;
    logic        wr_ready, dotWren, is_Yloc, overflow;
    logic [31:0] dotID, dotLoc;
    logic [4:0]  level;
    logic [7:0]  drop_count;

    dot_update_queue dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_is_y(wr_is_y),
        .wr_id(wr_id), .wr_loc(wr_loc), .wr_ready(wr_ready),
        .screen_end(screen_end), .active(active), .dotWren(dotWren),
        .is_Yloc(is_Yloc), .dotID(dotID), .dotLoc(dotLoc), .level(level),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        y;
        logic [31:0] id;
        logic [31:0] loc;
    } ent_t;

    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    ent_t mdl[$];
    ent_t obs[$];
    int   scyc[$];
    bit   ovf_m = 1'b0;
    int   drop_m = 0;
    bit   allow = 1'b0;
    bit   mon_on = 1'b0;
    bit   prev_wren = 1'b0;
    int   n_strobe = 0;
    int   n, base, ob, cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic event_fail(input string name, input bit bad, input string what);
        checks++;
        if (bad) begin
            errs++;
            $display("FAIL %s: %s", name, what);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (mon_on) begin
            check("level", 32'(level), 32'(mdl.size()));
            check("wr_ready", 32'(wr_ready), 32'(mdl.size() < 16));
            check("overflow", 32'(overflow), 32'(ovf_m));
            check("drop_count", 32'(drop_count), 32'(drop_m));
            if (dotWren) begin
                n_strobe++;
                obs.push_back('{is_Yloc, dotID, dotLoc});
                scyc.push_back(cyc);
                event_fail("strobe_window", !allow, "dotWren=1 required 0 outside replay window");
                event_fail("strobe_gap", prev_wren, "dotWren=1 required 0 after previous strobe");
                event_fail("strobe_extra", mdl.size() == 0, "dotWren=1 required 0 with no entry expected");
                if (mdl.size() != 0) begin
                    check("is_Yloc", 32'(is_Yloc), 32'(mdl[0].y));
                    check("dotID", dotID, mdl[0].id);
                    check("dotLoc", dotLoc, mdl[0].loc);
                    void'(mdl.pop_front());
                end
            end
            prev_wren = dotWren;
        end
    end

    // Drive one write and apply acceptance rules to the model at the sampling edge.
    task automatic do_write(input logic y, input logic [31:0] id, input logic [31:0] loc);
        ent_t e;
        wr_valid = 1'b1;
        wr_is_y  = y;
        wr_id    = id;
        wr_loc   = loc;
        @(posedge clk);
        if (id >= 32'd20) drop_m = (drop_m == 255) ? 255 : drop_m + 1;
        if (mdl.size() >= 16) begin
            ovf_m = 1'b1;
        end else if (id < 32'd20) begin
            e.y   = y;
            e.id  = id;
            if (y) e.loc = (loc > 32'd479) ? 32'd479 : loc;
            else   e.loc = (loc > 32'd639) ? 32'd639 : loc;
            mdl.push_back(e);
        end
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic se_rise(output int start_cyc);
        @(posedge clk);
        #1;
        screen_end = 1'b1;
        start_cyc  = cyc;
    endtask

    task automatic pulse(output int start_cyc);
        se_rise(start_cyc);
        idle(4);
        screen_end = 1'b0;
    endtask

    initial begin
        #2;
        reset  = 1'b0;
        mon_on = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(1);
        check("rst_wren", 32'(dotWren), 0);
        check("rst_level", 32'(level), 0);
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_dotID", dotID, 0);
        check("rst_dotLoc", dotLoc, 0);

        // empty FIFO: no strobes over three frame starts
        allow = 1'b0;
        base  = n_strobe;
        for (int i = 0; i < 3; i++) begin
            pulse(n);
            idle(4);
        end
        check("idle_strobes", 32'(n_strobe - base), 0);

        // basic replay and latency
        do_write(1'b0, 32'd3, 32'd100);
        do_write(1'b1, 32'd3, 32'd200);
        allow = 1'b1;
        base  = n_strobe;
        ob    = obs.size();
        pulse(n);
        idle(10);
        check("basic_count", 32'(n_strobe - base), 2);
        if (obs.size() >= ob + 2) begin
            check("basic_t0", 32'(scyc[ob]), 32'(n + 1));
            check("basic_t1", 32'(scyc[ob + 1]), 32'(n + 3));
            check("basic_id0", obs[ob].id, 3);
            check("basic_y0", 32'(obs[ob].y), 0);
            check("basic_loc0", obs[ob].loc, 100);
            check("basic_y1", 32'(obs[ob + 1].y), 1);
            check("basic_loc1", obs[ob + 1].loc, 200);
        end
        check("basic_level", 32'(level), 0);

        // clamping and ID rejection
        allow = 1'b0;
        do_write(1'b0, 32'd1, 32'd700);
        do_write(1'b1, 32'd2, 32'hFFFF_FFFF);
        do_write(1'b0, 32'd20, 32'd5);
        idle(1);
        check("clamp_drop", 32'(drop_count), 1);
        allow = 1'b1;
        base  = n_strobe;
        ob    = obs.size();
        pulse(n);
        idle(10);
        check("clamp_count", 32'(n_strobe - base), 2);
        if (obs.size() >= ob + 2) begin
            check("clamp_x", obs[ob].loc, 639);
            check("clamp_y", obs[ob + 1].loc, 479);
            check("clamp_id", obs[ob + 1].id, 2);
        end

        // full FIFO: 17th write rejected
        allow = 1'b0;
        for (int i = 0; i < 17; i++) do_write(1'b0, 32'(i), 32'(i * 10));
        idle(1);
        check("full_level", 32'(level), 16);
        check("full_wr_ready", 32'(wr_ready), 0);
        check("full_overflow", 32'(overflow), 1);
        allow = 1'b1;
        base  = n_strobe;
        ob    = obs.size();
        pulse(n);
        idle(40);
        check("full_count", 32'(n_strobe - base), 16);
        if (obs.size() >= ob + 16) begin
            check("full_last_id", obs[ob + 15].id, 15);
            check("full_last_loc", obs[ob + 15].loc, 150);
        end
        check("full_level_after", 32'(level), 0);

        // active rises after the 4th strobe
        allow = 1'b0;
        for (int i = 0; i < 10; i++) do_write(1'b1, 32'(i), 32'(i + 300));
        allow = 1'b1;
        base  = n_strobe;
        se_rise(n);
        cnt = 0;
        for (int k = 0; k < 40 && cnt < 4; k++) begin
            @(posedge clk);
            #1;
            if (dotWren) cnt++;
        end
        event_fail("active_wait", cnt < 4, "timed out waiting for 4 strobes");
        active = 1'b1;
        idle(10);
        screen_end = 1'b0;
        check("active_count", 32'(n_strobe - base), 4);
        check("active_level", 32'(level), 6);
        idle(2);
        active = 1'b0;
        base   = n_strobe;
        pulse(n);
        idle(20);
        check("active_rest", 32'(n_strobe - base), 6);
        check("active_level_after", 32'(level), 0);

        // reset during a drain
        allow = 1'b0;
        for (int i = 0; i < 5; i++) do_write(1'b0, 32'(i), 32'(i));
        allow = 1'b1;
        se_rise(n);
        cnt = 0;
        for (int k = 0; k < 20 && cnt < 1; k++) begin
            @(posedge clk);
            #1;
            if (dotWren) cnt++;
        end
        event_fail("rst_mid_wait", cnt < 1, "timed out waiting for first strobe");
        reset = 1'b0;
        mdl.delete();
        ovf_m  = 1'b0;
        drop_m = 0;
        #1;
        check("rst_mid_wren", 32'(dotWren), 0);
        check("rst_mid_level", 32'(level), 0);
        check("rst_mid_overflow", 32'(overflow), 0);
        idle(3);
        screen_end = 1'b0;
        reset = 1'b1;
        idle(2);
        allow = 1'b0;
        base  = n_strobe;
        pulse(n);
        idle(15);
        check("rst_mid_after", 32'(n_strobe - base), 0);
        check("rst_mid_level_after", 32'(level), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dot_update_queue.md
Name: dot_update_queue

Overview:
- Sits directly upstream of the VGA controller's dot-update port (dotWren / is_Yloc / dotID / dotLoc).
- Accepts dot-position writes from the processor at any time and buffers them in a FIFO.
- Replays the writes only during vertical blanking, starting at each screenEnd, so dot registers never change mid-frame.
- Issues each write as an isolated one-cycle dotWren pulse, separated by at least one low cycle, because the controller updates on posedge dotWren.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2.
- NUM_DOTS, 20: valid dot IDs are 0..NUM_DOTS-1.
- MAX_PER_FRAME, 64: maximum writes replayed per blanking interval.
- X_MAX, 639: x clamp value.
- Y_MAX, 479: y clamp value.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  processor write request.
- wr_is_y  in  1  1 = y coordinate, 0 = x coordinate.
- wr_id  in  32  dot index.
- wr_loc  in  32  coordinate value.
- wr_ready  out  1  FIFO not full.
- screen_end  in  1  screenEnd from the timing generator; high for several clk cycles.
- active  in  1  timing generator active flag; high while drawing.
- dotWren  out  1  write strobe to the controller.
- is_Yloc  out  1  coordinate select to the controller.
- dotID  out  32  dot index to the controller.
- dotLoc  out  32  coordinate to the controller.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: write attempted while full.
- drop_count  out  8  saturating count of rejected IDs.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; level=0; wr_ready=1.
  - dotWren=0, is_Yloc=0, dotID=0, dotLoc=0.
  - overflow=0, drop_count=0; FSM to IDLE; screen_end history register cleared.
  - Reset asserted mid-drain aborts the drain; un-replayed entries are lost.
- Write acceptance (rising edge):
  - A write is accepted when wr_valid=1 and level<DEPTH.
  - An accepted entry stores {wr_is_y, wr_id[4:0], clamped loc}; entry width is 1+5+10 bits.
- Clamping:
  - x: loc > X_MAX stores X_MAX, else loc[9:0].
  - y: loc > Y_MAX stores Y_MAX, else loc[8:0] zero-extended to 10 bits.
  - Comparisons use the full 32 bits, so loc=32'hFFFF_FFFF clamps.
- ID check:
  - wr_valid with wr_id >= NUM_DOTS (full 32-bit compare) is not stored.
  - drop_count increments, saturating at 255; wr_ready is unaffected.
- Full FIFO:
  - wr_valid while level==DEPTH: write discarded, overflow set (sticky).
  - A pop in the same cycle does not admit the write; wr_ready is registered from level before the pop.
- Level accounting:
  - Simultaneous accepted push and pop leave level unchanged.
  - FIFO pointers wrap modulo DEPTH.
- Frame-start detection: se_q <= screen_end; start = screen_end & ~se_q.
- FSM:
  - IDLE:
    - If start=1 and level>0: load budget=MAX_PER_FRAME and go to STROBE.
    - Otherwise stay in IDLE. start is ignored outside IDLE.
  - STROBE (1 cycle):
    - dotWren=1; is_Yloc, dotID (zero-extended), dotLoc (zero-extended) are driven from the head entry.
    - Head entry popped at the end of this cycle; budget decrements.
    - Go to GAP.
  - GAP (1 cycle):
    - dotWren=0; data outputs hold their last values.
    - Return to STROBE if level>0, budget>0 and active=0; otherwise go to IDLE.
- All outputs are registered.
- Latency:
  - screen_end rises at edge N (start seen at N): dotWren is high from edge N+1, first write.
  - Subsequent writes start at N+3, N+5, ...
  - Throughput is one write per 2 clk cycles.
- Blanking boundaries:
  - If active rises during a drain, the current strobe completes; the drain stops after GAP.
  - The remaining entries wait for the next screen_end.
- Ordering: entries replay in FIFO order. Two writes to the same dot/axis both replay, so the last one wins in the controller.
- Budget: budget exhaustion leaves the remaining entries for the next frame.

Test Plan:
- Reset then idle: after reset deasserts, dotWren=0, level=0, wr_ready=1, overflow=0; no strobes over 3 screen_end pulses with an empty FIFO.
- Basic replay:
  - Stimulus: write (x, id 3, 100), then (y, id 3, 200); hold active=0; pulse screen_end at cycle N.
  - Required: dotWren high at N+1 with dotID=3, is_Yloc=0, dotLoc=100; dotWren high at N+3 with is_Yloc=1, dotLoc=200; level returns to 0.
- Clamp and ID drop:
  - Stimulus: write x=700, y=32'hFFFFFFFF, then id=20.
  - Required: replayed locs are 639 and 479; id-20 write is absent; drop_count=1.
- Full FIFO:
  - Stimulus: 17 writes with no screen_end.
  - Required: level=16; wr_ready=0; overflow=1; only the first 16 entries replay in order.
- Active interrupt:
  - Stimulus: 10 entries queued; active rises after the 4th strobe.
  - Required: exactly 4 strobes; level=6; the remaining 6 replay after the next screen_end.
- Reset mid-drain:
  - Stimulus: assert reset during STROBE with 5 entries pending.
  - Required: dotWren drops to 0 immediately (asynchronous); level=0; no strobes on the next screen_end.
